// File: rtl/wddl_gate_bank.sv
// Bank of WDDL dual-rail gates (OR/AND/NOR/NAND) with precharge/evaluate sequencing.
// Latency: capture at edge k, result valid from cycle k+2+EVAL_CYCLES until taken.
// Backpressure: in_ready only in IDLE; result held stable in DONE while out_ready=0.
module wddl_gate_bank #(
  parameter int WIDTH       = 8,
  parameter int EVAL_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_t,
  input  logic [WIDTH-1:0] a_f,
  input  logic [WIDTH-1:0] b_t,
  input  logic [WIDTH-1:0] b_f,
  output logic [WIDTH-1:0] y_t,
  output logic [WIDTH-1:0] y_f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] err_lane,
  output logic [15:0]      op_cnt
);

  typedef enum logic [1:0] {IDLE, PRE, EVAL, DONE} state_t;

  localparam logic [3:0] EVAL_LOAD = 4'(EVAL_CYCLES);

  state_t           state_q, state_d;
  logic [3:0]       eval_cnt_q, eval_cnt_d;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_t_q, a_f_q, b_t_q, b_f_q;
  logic [WIDTH-1:0] res_t, res_f;
  logic [WIDTH-1:0] y_t_d, y_f_d;
  logic             accept;
  logic             take;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign take      = out_valid && out_ready;

  // Dual-rail gate evaluation from captured operands; negated ops only swap rails.
  always_comb begin
    res_t = '0;
    res_f = '0;
    case (op_q)
      2'b00: begin res_t = a_t_q | b_t_q; res_f = a_f_q & b_f_q; end
      2'b01: begin res_t = a_t_q & b_t_q; res_f = a_f_q | b_f_q; end
      2'b10: begin res_t = a_f_q & b_f_q; res_f = a_t_q | b_t_q; end
      default: begin res_t = a_f_q | b_f_q; res_f = a_t_q & b_t_q; end
    endcase
    // Lanes with invalid input rails stay in the precharge (0,0) code.
    res_t = res_t & ~err_lane;
    res_f = res_f & ~err_lane;
  end

  // Next-state logic for the precharge/evaluate wave and eval down-counter.
  always_comb begin
    state_d    = state_q;
    eval_cnt_d = eval_cnt_q;
    case (state_q)
      IDLE: if (accept) state_d = PRE;
      PRE: begin
        state_d    = EVAL;
        eval_cnt_d = EVAL_LOAD;
      end
      EVAL: begin
        if (eval_cnt_q <= 4'd1) begin
          state_d    = DONE;
          eval_cnt_d = 4'd0;
        end else begin
          eval_cnt_d = eval_cnt_q - 4'd1;
        end
      end
      default: if (take) state_d = IDLE;
    endcase
  end

  // Output rails: load on DONE entry, hold while in DONE, precharge otherwise.
  always_comb begin
    y_t_d = '0;
    y_f_d = '0;
    if (state_d == DONE) begin
      if (state_q == DONE) begin
        y_t_d = y_t;
        y_f_d = y_f;
      end else begin
        y_t_d = res_t;
        y_f_d = res_f;
      end
    end
  end

  // State, counters, operand capture and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      eval_cnt_q <= 4'd0;
      op_q       <= 2'b00;
      a_t_q      <= '0;
      a_f_q      <= '0;
      b_t_q      <= '0;
      b_f_q      <= '0;
      err_lane   <= '0;
      y_t        <= '0;
      y_f        <= '0;
      op_cnt     <= 16'd0;
    end else begin
      state_q    <= state_d;
      eval_cnt_q <= eval_cnt_d;
      y_t        <= y_t_d;
      y_f        <= y_f_d;
      if (accept) begin
        op_q     <= op;
        a_t_q    <= a_t;
        a_f_q    <= a_f;
        b_t_q    <= b_t;
        b_f_q    <= b_f;
        err_lane <= ~(a_t ^ a_f) | ~(b_t ^ b_f);
      end
      if (take) op_cnt <= op_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_wddl_gate_bank.sv
// Directed bench for wddl_gate_bank: one instance with EVAL_CYCLES=1, one with 3.
// Inputs driven and outputs sampled on the falling edge.
// Ends with a single summary line.
module tb_wddl_gate_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] op;
  logic [7:0] a_t, a_f, b_t, b_f;

  logic        iv1, ir1, ov1, or1;
  logic [7:0]  yt1, yf1, err1;
  logic [15:0] cnt1;

  logic        iv3, ir3, ov3, or3;
  logic [7:0]  yt3, yf3, err3;
  logic [15:0] cnt3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wddl_gate_bank #(.WIDTH(8), .EVAL_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .op(op),
    .a_t(a_t), .a_f(a_f), .b_t(b_t), .b_f(b_f), .y_t(yt1), .y_f(yf1),
    .out_valid(ov1), .out_ready(or1), .err_lane(err1), .op_cnt(cnt1)
  );

  wddl_gate_bank #(.WIDTH(8), .EVAL_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .op(op),
    .a_t(a_t), .a_f(a_f), .b_t(b_t), .b_f(b_f), .y_t(yt3), .y_f(yf3),
    .out_valid(ov3), .out_ready(or3), .err_lane(err3), .op_cnt(cnt3)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full operation on the EVAL_CYCLES=1 instance; entered and left at a negedge.
  task automatic run1(input string tag, input logic [1:0] o,
                      input logic [7:0] at, input logic [7:0] af,
                      input logic [7:0] bt, input logic [7:0] bf,
                      input logic [7:0] et, input logic [7:0] ef,
                      input logic [7:0] ee, input logic [15:0] ecnt);
    op = o; a_t = at; a_f = af; b_t = bt; b_f = bf;
    iv1 = 1'b1; or1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Scramble inputs after capture; the result must not follow them.
    iv1 = 1'b0; op = ~o; a_t = ~at; a_f = ~af; b_t = bf; b_f = bt;
    chk({tag, "_pre"}, {ov1, ir1, yt1, yf1}, 18'h0);
    chk({tag, "_err"}, err1, ee);
    @(negedge clk);
    chk({tag, "_eval"}, {ov1, ir1, yt1, yf1}, 18'h0);
    @(negedge clk);
    chk({tag, "_done"}, {ov1, yt1, yf1}, {1'b1, et, ef});
    @(negedge clk);
    chk({tag, "_after"}, {ov1, ir1, yt1, yf1}, {1'b0, 1'b1, 16'h0});
    chk({tag, "_cnt"}, cnt1, ecnt);
    chk({tag, "_errhold"}, err1, ee);
  endtask

  initial begin
    int stable_bad;
    logic [7:0] hold_t, hold_f;
    rst_n = 1'b0; op = 2'b00; a_t = 8'h0; a_f = 8'h0; b_t = 8'h0; b_f = 8'h0;
    iv1 = 1'b0; or1 = 1'b0; iv3 = 1'b0; or3 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset_state", {ov1, ir1, yt1, yf1, err1, cnt1}, {1'b0, 1'b1, 40'h0});
    chk("reset_state3", {ov3, ir3, yt3, yf3, err3, cnt3}, {1'b0, 1'b1, 40'h0});

    // Reset during EVAL on the 3-cycle instance, with an erroneous lane captured.
    op = 2'b01; a_t = 8'hFF; a_f = 8'h04; b_t = 8'hFF; b_f = 8'h00; iv3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv3 = 1'b0;
    chk("rst_mid_err_set", err3, 8'h04);
    @(negedge clk);
    chk("rst_mid_in_eval", {ov3, ir3, yt3, yf3}, 18'h0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_outs", {ov3, yt3, yf3, err3, cnt3}, {1'b0, 40'h0});
    chk("rst_mid_ready", ir3, 1'b1);
    repeat (4) @(negedge clk);
    chk("rst_mid_no_result", {ov3, cnt3}, 17'h0);

    // Directed operations on the EVAL_CYCLES=1 instance.
    run1("or",   2'b00, 8'h0F, 8'hF0, 8'h33, 8'hCC, 8'h3F, 8'hC0, 8'h00, 16'd1);
    run1("nand", 2'b11, 8'h0F, 8'hF0, 8'h33, 8'hCC, 8'hFC, 8'h03, 8'h00, 16'd2);
    run1("and_err", 2'b01, 8'hFF, 8'h04, 8'hFF, 8'h00, 8'hFB, 8'h00, 8'h04, 16'd3);
    run1("nor",  2'b10, 8'h0F, 8'hF0, 8'h33, 8'hCC, 8'hC0, 8'h3F, 8'h00, 16'd4);
    run1("and",  2'b01, 8'hA5, 8'h5A, 8'h3C, 8'hC3, 8'h24, 8'hDB, 8'h00, 16'd5);
    run1("b_err", 2'b00, 8'h0F, 8'hF0, 8'h33, 8'hCD, 8'h3E, 8'hC0, 8'h01, 16'd6);

    // EVAL_CYCLES=3 with the consumer stalled for 5 cycles.
    op = 2'b00; a_t = 8'h0F; a_f = 8'hF0; b_t = 8'h33; b_f = 8'hCC;
    iv3 = 1'b1; or3 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    iv3 = 1'b0; a_t = 8'h00; a_f = 8'hFF;
    chk("e3_k1", {ov3, yt3, yf3}, 17'h0);
    repeat (3) @(negedge clk);
    chk("e3_k4", {ov3, yt3, yf3}, 17'h0);
    @(negedge clk);
    chk("e3_k5", {ov3, yt3, yf3}, {1'b1, 8'h3F, 8'hC0});
    hold_t = 8'h3F; hold_f = 8'hC0;
    stable_bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!ov3 || yt3 !== hold_t || yf3 !== hold_f) stable_bad++;
    end
    chk("e3_stall_stable", stable_bad, 0);
    chk("e3_stall_cnt", cnt3, 16'd0);
    or3 = 1'b1;
    @(negedge clk);
    or3 = 1'b0;
    chk("e3_take", {ov3, ir3, yt3, yf3, cnt3}, {1'b0, 1'b1, 16'h0, 16'd1});
    repeat (2) @(negedge clk);
    chk("e3_cnt_once", cnt3, 16'd1);

    // Counter wrap: preload the count register, then complete one operation.
    force dut.op_cnt = 16'hFFFF;
    #1;
    release dut.op_cnt;
    chk("wrap_preload", cnt1, 16'hFFFF);
    run1("wrap", 2'b00, 8'h0F, 8'hF0, 8'h33, 8'hCC, 8'h3F, 8'hC0, 8'h00, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
